// File: rtl/hash_fmt_pkg.sv
// Shared definitions for the hash digest formatter.
//   - mode encodings for the supported digest types
//   - per-mode digest word counts and byte lengths
//   - FSM state type for the byte streamer
//   - helper mapping a mode to its word count (0 for the reserved mode)
package hash_fmt_pkg;

    localparam logic [1:0] MODE_MD5    = 2'd0;
    localparam logic [1:0] MODE_SHA1   = 2'd1;
    localparam logic [1:0] MODE_SHA256 = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int unsigned MD5_WORDS    = 4;
    localparam int unsigned SHA1_WORDS   = 5;
    localparam int unsigned SHA256_WORDS = 8;

    localparam int unsigned MD5_BYTES    = 16;
    localparam int unsigned SHA1_BYTES   = 20;
    localparam int unsigned SHA256_BYTES = 32;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    function automatic int unsigned words_for_mode(input logic [1:0] mode);
        int unsigned n;
        case (mode)
            MODE_MD5:    n = MD5_WORDS;
            MODE_SHA1:   n = SHA1_WORDS;
            MODE_SHA256: n = SHA256_WORDS;
            default:     n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hash_byte_order.sv
// Combinational digest re-ordering.
// Ports:
//   digest_in  raw core output; word k of an N-word digest sits at
//              digest_in[32*(N-k)-1 -: 32] (word 0 is the MSW of the used field)
//   mode       digest type (MD5 / SHA-1 / SHA-256 / reserved)
//   result     canonical byte order, byte j at bits [8j+7:8j]; bits >= 32*N are 0
//   len        digest length in bytes (0 for the reserved mode)
module hash_byte_order
    import hash_fmt_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned RESULT_W  = 1024,
    parameter int unsigned LEN_W     = 8
) (
    input  logic [32*MAX_WORDS-1:0] digest_in,
    input  logic [1:0]              mode,
    output logic [RESULT_W-1:0]     result,
    output logic [LEN_W-1:0]        len
);

    int unsigned               n_words;
    logic [32*MAX_WORDS-1:0]   shifted;
    logic [31:0]               word;

    always_comb begin
        result  = '0;
        shifted = '0;
        word    = '0;
        n_words = words_for_mode(mode);
        len     = LEN_W'(4 * n_words);
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (k < n_words) begin
                // Bring word k down to the bottom 32 bits.
                shifted = digest_in >> (32 * (n_words - 1 - k));
                word    = shifted[31:0];
                for (int b = 0; b < 4; b++) begin
                    if (mode == MODE_MD5) begin
                        result[32*k + 8*b +: 8] = word[8*b +: 8];
                    end else begin
                        result[32*k + 8*b +: 8] = word[31 - 8*b -: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hash_digest_formatter.sv
// Hash digest formatter: captures a raw MD5/SHA-1/SHA-256 digest, publishes it in
// canonical byte order on a wide parallel bus, and streams it out a byte at a time.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mode, digest_in             digest type and raw core output
//   in_valid / in_ready         input handshake (ready only while idle)
//   MD5_result, MD5_result_len  registered formatted digest and its byte length
//   out_byte/out_valid/out_ready/out_last  byte stream handshake
//   err                         sticky flag for an accepted reserved mode
module hash_digest_formatter
    import hash_fmt_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned RESULT_W  = 1024,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [32*MAX_WORDS-1:0] digest_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [RESULT_W-1:0]     MD5_result,
    output logic [LEN_W-1:0]        MD5_result_len,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    err
);

    localparam int unsigned NBYTES = 4 * MAX_WORDS;
    localparam int unsigned CNT_W  = $clog2(NBYTES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                err_q, err_d;

    logic [RESULT_W-1:0] fmt_result;
    logic [LEN_W-1:0]    fmt_len;
    logic [7:0]          res_bytes [NBYTES];
    logic                accept;
    logic                last_byte;

    hash_byte_order #(
        .MAX_WORDS (MAX_WORDS),
        .RESULT_W  (RESULT_W),
        .LEN_W     (LEN_W)
    ) u_byte_order (
        .digest_in (digest_in),
        .mode      (mode),
        .result    (fmt_result),
        .len       (fmt_len)
    );

    always_comb begin
        for (int j = 0; j < NBYTES; j++) begin
            res_bytes[j] = result_q[8*j +: 8];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_byte = (LEN_W'(cnt_q) == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        len_d     = len_q;
        err_d     = err_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (mode == MODE_RSVD) begin
                        // Reserved mode is consumed but never streamed.
                        err_d    = 1'b1;
                        result_d = '0;
                        len_d    = '0;
                    end else begin
                        err_d    = 1'b0;
                        result_d = fmt_result;
                        len_d    = fmt_len;
                        state_d  = STREAM;
                    end
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = last_byte;
                out_byte  = res_bytes[cnt_q];
                if (out_ready) begin
                    if (last_byte) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            len_q    <= len_d;
            err_q    <= err_d;
        end
    end

    assign MD5_result     = result_q;
    assign MD5_result_len = len_q;
    assign err            = err_q;

endmodule

// File: tb/tb_hash_digest_formatter.sv
// Directed bench for hash_digest_formatter; inputs driven and outputs sampled on
// the falling clock edge.
module tb_hash_digest_formatter;
    import hash_fmt_pkg::*;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic [255:0]  digest_in;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] MD5_result;
    logic [7:0]    MD5_result_len;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    hash_digest_formatter #(
        .MAX_WORDS (8),
        .RESULT_W  (1024),
        .LEN_W     (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .digest_in      (digest_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .MD5_result     (MD5_result),
        .MD5_result_len (MD5_result_len),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Hand-written digests and their canonical forms.
    localparam logic [255:0] MD5_IN =
        {128'hDEADBEEF_CAFEF00D_0BADF00D_FEEDFACE,
         32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    localparam logic [127:0] MD5_OUT = 128'h76543210_FEDCBA98_89ABCDEF_01234567;
    localparam logic [255:0] SHA1_IN =
        {96'hAAAAAAAA_BBBBBBBB_CCCCCCCC,
         32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
    localparam logic [159:0] SHA1_OUT =
        160'hF0E1D2C3_76543210_FEDCBA98_89ABCDEF_01234567;
    localparam logic [255:0] SHA256_IN =
        256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [255:0] SHA256_OUT =
        256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept_digest(input logic [1:0] m, input logic [255:0] d);
        mode      = m;
        digest_in = d;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    // Drain a stream; bp selects the 1,0,0,1 out_ready pattern.
    task automatic run_stream(input bit bp, input int maxcyc, output int ntx,
                              output logic [255:0] got, output logic [31:0] lastmask,
                              output bit stable_ok, output bit rdy_ok);
        bit         stalled;
        bit         done;
        logic [7:0] pb;
        logic       pl;
        ntx = 0; got = '0; lastmask = '0; stable_ok = 1; rdy_ok = 1;
        stalled = 0; done = 0; pb = '0; pl = 1'b0;
        for (int c = 0; c < maxcyc && !done; c++) begin
            if (stalled && (out_byte !== pb || out_last !== pl || out_valid !== 1'b1))
                stable_ok = 0;
            if (out_valid !== 1'b1) begin
                done = 1;
            end else begin
                if (in_ready !== 1'b0) rdy_ok = 0;
                out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
                if (out_ready) begin
                    if (ntx < 32) begin
                        got[8*ntx +: 8] = out_byte;
                        lastmask[ntx]   = out_last;
                    end
                    ntx++;
                    stalled = 0;
                    if (out_last) begin
                        in_valid = 1'b0;
                        done     = 1;
                    end
                end else begin
                    stalled = 1;
                    pb      = out_byte;
                    pl      = out_last;
                end
                step();
            end
        end
        out_ready = 1'b0;
    endtask

    int           ntx;
    logic [255:0] got;
    logic [31:0]  lastmask;
    bit           stable_ok;
    bit           rdy_ok;
    bit           ov_seen;
    int           acc_cyc [3];
    int           acc_len [3];
    logic [7:0]   acc_b0  [3];
    int           nacc;
    bit           switch_pending;

    initial begin
        rst = 1'b1; mode = MODE_MD5; digest_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset out_byte", out_byte, 0);
        chk("reset result", MD5_result, 0);
        chk("reset len", MD5_result_len, 0);
        chk("reset err", err, 0);

        // MD5 little-endian path.
        accept_digest(MODE_MD5, MD5_IN);
        chk("md5 result", MD5_result, MD5_OUT);
        chk("md5 len", MD5_result_len, 16);
        chk("md5 out_valid", out_valid, 1);
        chk("md5 in_ready", in_ready, 0);
        chk("md5 byte0", out_byte, 8'h67);
        run_stream(0, 100, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("md5 transfers", ntx, 16);
        chk("md5 stream", got[127:0], MD5_OUT);
        chk("md5 byte1", got[15:8], 8'h45);
        chk("md5 byte15", got[127:120], 8'h76);
        chk("md5 last mask", lastmask, 32'h0000_8000);
        chk("md5 idle out_valid", out_valid, 0);
        chk("md5 idle in_ready", in_ready, 1);
        chk("md5 result hold", MD5_result, MD5_OUT);

        // SHA-1 big-endian path.
        accept_digest(MODE_SHA1, SHA1_IN);
        chk("sha1 result", MD5_result, SHA1_OUT);
        chk("sha1 len", MD5_result_len, 20);
        run_stream(0, 100, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("sha1 transfers", ntx, 20);
        chk("sha1 byte0", got[7:0], 8'h67);
        chk("sha1 byte3", got[31:24], 8'h01);
        chk("sha1 byte19", got[159:152], 8'hF0);
        chk("sha1 last mask", lastmask, 32'h0008_0000);

        // SHA-256 with backpressure and an ignored in_valid during the stream.
        accept_digest(MODE_SHA256, SHA256_IN);
        chk("sha256 result", MD5_result, SHA256_OUT);
        chk("sha256 len", MD5_result_len, 32);
        mode = MODE_MD5; digest_in = MD5_IN; in_valid = 1'b1;
        run_stream(1, 300, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("sha256 transfers", ntx, 32);
        chk("sha256 stream", got, SHA256_OUT);
        chk("sha256 last mask", lastmask, 32'h8000_0000);
        chk("sha256 stall stable", stable_ok, 1);
        chk("sha256 in_ready low", rdy_ok, 1);
        chk("sha256 len after", MD5_result_len, 32);
        chk("sha256 result after", MD5_result, SHA256_OUT);
        chk("sha256 idle out_valid", out_valid, 0);

        // Reserved mode.
        accept_digest(MODE_RSVD, SHA256_IN);
        chk("rsvd err", err, 1);
        chk("rsvd len", MD5_result_len, 0);
        chk("rsvd result", MD5_result, 0);
        chk("rsvd in_ready", in_ready, 1);
        ov_seen = 0;
        repeat (5) begin
            if (out_valid !== 1'b0) ov_seen = 1;
            step();
        end
        chk("rsvd no out_valid", ov_seen, 0);
        chk("rsvd err sticky", err, 1);
        accept_digest(MODE_MD5, MD5_IN);
        chk("rsvd err cleared", err, 0);
        chk("rsvd md5 len", MD5_result_len, 16);
        run_stream(0, 100, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("rsvd md5 transfers", ntx, 16);

        // Reset mid-stream, with in_valid raised in the reset cycle.
        accept_digest(MODE_SHA256, SHA256_IN);
        out_ready = 1'b1;
        repeat (5) step();
        chk("midrst byte5", out_byte, 8'h05);
        rst = 1'b1; mode = MODE_MD5; digest_in = MD5_IN; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst result", MD5_result, 0);
        chk("midrst len", MD5_result_len, 0);
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_byte", out_byte, 0);
        accept_digest(MODE_MD5, MD5_IN);
        chk("postrst byte0", out_byte, 8'h67);
        run_stream(0, 100, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("postrst transfers", ntx, 16);
        chk("postrst stream", got[127:0], MD5_OUT);

        // Back-to-back: in_valid held high, MD5 -> SHA-256 -> MD5.
        mode = MODE_MD5; digest_in = MD5_IN; in_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; switch_pending = 0;
        for (int cyc = 0; cyc < 200 && nacc < 3; cyc++) begin
            if (switch_pending) begin
                switch_pending = 0;
                chk("b2b start len", MD5_result_len, acc_len[nacc-1]);
                chk("b2b start byte0", out_byte, acc_b0[nacc-1]);
                if (mode == MODE_MD5) begin
                    mode = MODE_SHA256; digest_in = SHA256_IN;
                end else begin
                    mode = MODE_MD5; digest_in = MD5_IN;
                end
            end
            if (in_ready === 1'b1) begin
                acc_cyc[nacc]  = cyc;
                acc_len[nacc]  = (mode == MODE_MD5) ? 16 : 32;
                acc_b0[nacc]   = (mode == MODE_MD5) ? 8'h67 : 8'h00;
                nacc++;
                switch_pending = 1;
            end
            step();
        end
        in_valid = 1'b0;
        chk("b2b accept count", nacc, 3);
        if (nacc == 3) begin
            chk("b2b last len", MD5_result_len, acc_len[2]);
            chk("b2b last byte0", out_byte, acc_b0[2]);
            // Inclusive span from one accept cycle to the next.
            chk("b2b span md5", acc_cyc[1] - acc_cyc[0] + 1, 16 + 2);
            chk("b2b span sha256", acc_cyc[2] - acc_cyc[1] + 1, 32 + 2);
        end
        run_stream(0, 100, ntx, got, lastmask, stable_ok, rdy_ok);
        chk("b2b drain transfers", ntx, 16);
        chk("b2b drain stream", got[127:0], MD5_OUT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
